// File: rtl/alu_ctrl_seq.sv
// rtl/alu_ctrl_seq.sv - Registered ALU control decoder with mul/div sequencing (optional div: ALU_CTRL_SEQ_DIV_EN)
module alu_ctrl_seq #(
    parameter int CTRL_W = 4,
    parameter int MD_LAT = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        alu_op,
    input  logic [5:0]        funct,
    output logic              out_valid,
    output logic [CTRL_W-1:0] alu_ctrl,
    output logic              illegal,
    output logic              md_start,
    output logic [1:0]        md_kind,
    output logic              stall
);

    typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

    // Counter preload: the md_start cycle itself counts as the first busy cycle.
    localparam logic [7:0] LAT_M1 = 8'(MD_LAT - 1);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       out_valid_q, out_valid_d;
    logic [3:0] code_q, code_d;
    logic       illegal_q, illegal_d;
    logic       md_start_q, md_start_d;
    logic [1:0] md_kind_q, md_kind_d;

    logic       accept;
    logic [3:0] dec_code;
    logic       dec_illegal;
    logic       dec_md;
    logic [1:0] dec_kind;

    assign accept = in_valid && in_ready;

    // Decode alu_op / funct into a control code and a mul/div flag.
    always_comb begin
        dec_code    = 4'b0000;
        dec_illegal = 1'b0;
        dec_md      = 1'b0;
        dec_kind    = 2'b00;
        case (alu_op)
            2'b00: dec_code = 4'b0010;
            2'b01: dec_code = 4'b0011;
            2'b11: dec_code = 4'b0001;
            default: begin
                case (funct)
                    6'd32: dec_code = 4'b0010;
                    6'd34: dec_code = 4'b0011;
                    6'd36: dec_code = 4'b0000;
                    6'd37: dec_code = 4'b0001;
                    6'd39: dec_code = 4'b0101;
                    6'd42: dec_code = 4'b0100;
                    6'd0:  dec_code = 4'b0110;
                    6'd3:  dec_code = 4'b0111;
                    6'd2:  dec_code = 4'b1000;
                    6'd38: dec_code = 4'b1001;
                    6'd24: begin dec_code = 4'b1010; dec_md = 1'b1; dec_kind = 2'b00; end
                    6'd25: begin dec_code = 4'b1011; dec_md = 1'b1; dec_kind = 2'b01; end
`ifdef ALU_CTRL_SEQ_DIV_EN
                    6'd26: begin dec_code = 4'b1100; dec_md = 1'b1; dec_kind = 2'b10; end
                    6'd27: begin dec_code = 4'b1101; dec_md = 1'b1; dec_kind = 2'b11; end
`endif
                    default: dec_illegal = 1'b1;
                endcase
            end
        endcase
    end

    // State and latency counter register; reset wins over any accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: enter BUSY on a mul/div accept, leave when the counter has drained.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == S_IDLE) begin
            if (accept && dec_md) begin
                state_d = S_BUSY;
                cnt_d   = LAT_M1;
            end
        end else begin
            if (cnt_q == 8'd0) begin
                state_d = S_IDLE;
            end else begin
                cnt_d = cnt_q - 8'd1;
            end
        end
    end

    // Moore outputs decoded from the state register only.
    always_comb begin
        in_ready = (state_q == S_IDLE);
        stall    = (state_q == S_BUSY);
    end

    // Result and pulse next-state: single-cycle ops respond next cycle, mul/div on drain.
    always_comb begin
        out_valid_d = 1'b0;
        illegal_d   = 1'b0;
        md_start_d  = 1'b0;
        code_d      = code_q;
        md_kind_d   = md_kind_q;
        if (accept) begin
            code_d = dec_code;
            if (dec_md) begin
                md_start_d = 1'b1;
                md_kind_d  = dec_kind;
            end else begin
                out_valid_d = 1'b1;
                illegal_d   = dec_illegal;
            end
        end else if (state_q == S_BUSY && cnt_q == 8'd0) begin
            out_valid_d = 1'b1;
        end
    end

    // Result and pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            illegal_q   <= 1'b0;
            md_start_q  <= 1'b0;
            code_q      <= 4'b0000;
            md_kind_q   <= 2'b00;
        end else begin
            out_valid_q <= out_valid_d;
            illegal_q   <= illegal_d;
            md_start_q  <= md_start_d;
            code_q      <= code_d;
            md_kind_q   <= md_kind_d;
        end
    end

    // Widen the 4-bit code; bits above 3 are always zero.
    always_comb begin
        alu_ctrl      = '0;
        alu_ctrl[3:0] = code_q;
    end

    assign out_valid = out_valid_q;
    assign illegal   = illegal_q;
    assign md_start  = md_start_q;
    assign md_kind   = md_kind_q;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// tb/tb_alu_ctrl_seq.sv - Self-checking bench for alu_ctrl_seq
module tb_alu_ctrl_seq;

    localparam int CTRL_W = 6;
    localparam int MD_LAT = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        alu_op;
    logic [5:0]        funct;
    logic              out_valid;
    logic [CTRL_W-1:0] alu_ctrl;
    logic              illegal;
    logic              md_start;
    logic [1:0]        md_kind;
    logic              stall;

    alu_ctrl_seq #(.CTRL_W(CTRL_W), .MD_LAT(MD_LAT)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .funct(funct), .out_valid(out_valid), .alu_ctrl(alu_ctrl),
        .illegal(illegal), .md_start(md_start), .md_kind(md_kind), .stall(stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] op;
        logic [5:0] fn;
        logic [3:0] code;
        logic       ill;
    } vec_t;

    typedef struct {
        logic [3:0] code;
        logic       ill;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    bit   mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every out_valid pulse pops one expected result.
    always @(negedge clk) begin
        if (mon_en) begin
            if (out_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    check("unexpected_out_valid", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("alu_ctrl", 32'(alu_ctrl), {28'd0, e.code});
                    check("illegal", 32'(illegal), {31'd0, e.ill});
                end
            end else begin
                check("illegal_without_valid", 32'(illegal), 32'd0);
            end
        end
    end

    task automatic run_md(input logic [5:0] fn, input logic [3:0] code, input logic [1:0] kind);
        int lat;
        bit seen;
        in_valid = 1'b1; alu_op = 2'b10; funct = fn;
        sb.push_back('{code: code, ill: 1'b0});
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("md_start_pulse", 32'(md_start), 32'd1);
        check("md_kind", 32'(md_kind), 32'(kind));
        check("md_stall", 32'(stall), 32'd1);
        lat = 0;
        seen = 1'b0;
        for (int i = 0; i < MD_LAT + 5 && !seen; i++) begin
            @(negedge clk);
            lat++;
            if (out_valid === 1'b1) seen = 1'b1;
        end
        check("md_latency", 32'(lat), 32'(MD_LAT));
        @(posedge clk); #1;
    endtask

    vec_t vecs[15];

    initial begin
        vecs[0]  = '{op: 2'b10, fn: 6'd39, code: 4'b0101, ill: 1'b0};
        vecs[1]  = '{op: 2'b00, fn: 6'd0,  code: 4'b0010, ill: 1'b0};
        vecs[2]  = '{op: 2'b01, fn: 6'd0,  code: 4'b0011, ill: 1'b0};
        vecs[3]  = '{op: 2'b11, fn: 6'd0,  code: 4'b0001, ill: 1'b0};
        vecs[4]  = '{op: 2'b10, fn: 6'd63, code: 4'b0000, ill: 1'b1};
        vecs[5]  = '{op: 2'b10, fn: 6'd32, code: 4'b0010, ill: 1'b0};
        vecs[6]  = '{op: 2'b10, fn: 6'd34, code: 4'b0011, ill: 1'b0};
        vecs[7]  = '{op: 2'b10, fn: 6'd36, code: 4'b0000, ill: 1'b0};
        vecs[8]  = '{op: 2'b10, fn: 6'd37, code: 4'b0001, ill: 1'b0};
        vecs[9]  = '{op: 2'b10, fn: 6'd42, code: 4'b0100, ill: 1'b0};
        vecs[10] = '{op: 2'b10, fn: 6'd0,  code: 4'b0110, ill: 1'b0};
        vecs[11] = '{op: 2'b10, fn: 6'd3,  code: 4'b0111, ill: 1'b0};
        vecs[12] = '{op: 2'b10, fn: 6'd2,  code: 4'b1000, ill: 1'b0};
        vecs[13] = '{op: 2'b10, fn: 6'd38, code: 4'b1001, ill: 1'b0};
        vecs[14] = '{op: 2'b10, fn: 6'd1,  code: 4'b0000, ill: 1'b1};

        rst = 1'b1; in_valid = 1'b0; alu_op = 2'b00; funct = 6'd0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_alu_ctrl", 32'(alu_ctrl), 32'd0);
        check("rst_illegal", 32'(illegal), 32'd0);
        check("rst_md_start", 32'(md_start), 32'd0);
        check("rst_md_kind", 32'(md_kind), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        mon_en = 1'b1;
        @(posedge clk); #1;

        // Back-to-back single-cycle ops, one per clock.
        for (int i = 0; i < 15; i++) begin
            in_valid = 1'b1; alu_op = vecs[i].op; funct = vecs[i].fn;
            check("vec_in_ready", 32'(in_ready), 32'd1);
            sb.push_back('{code: vecs[i].code, ill: vecs[i].ill});
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("vec_drained", 32'(sb.size()), 32'd0);

        // mult with in_valid held through BUSY, then accepted again in the out_valid cycle.
        in_valid = 1'b1; alu_op = 2'b10; funct = 6'd24;
        sb.push_back('{code: 4'b1010, ill: 1'b0});
        @(posedge clk); #1;
        funct = 6'd32;
        for (int c = 1; c <= MD_LAT; c++) begin
            @(negedge clk);
            check("mult_md_start", 32'(md_start), (c == 1) ? 32'd1 : 32'd0);
            check("mult_md_kind", 32'(md_kind), 32'd0);
            check("mult_stall", 32'(stall), 32'd1);
            check("mult_in_ready", 32'(in_ready), 32'd0);
            check("mult_out_valid_early", 32'(out_valid), 32'd0);
            @(posedge clk); #1;
        end
        sb.push_back('{code: 4'b0010, ill: 1'b0});
        @(negedge clk);
        check("mult_done_valid", 32'(out_valid), 32'd1);
        check("mult_done_stall", 32'(stall), 32'd0);
        check("mult_done_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("no_bubble_valid", 32'(out_valid), 32'd1);
        @(posedge clk); #1;

        run_md(6'd25, 4'b1011, 2'b01);

`ifdef ALU_CTRL_SEQ_DIV_EN
        run_md(6'd26, 4'b1100, 2'b10);
        run_md(6'd27, 4'b1101, 2'b11);
`else
        in_valid = 1'b1; alu_op = 2'b10; funct = 6'd26;
        sb.push_back('{code: 4'b0000, ill: 1'b1});
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("div_off_valid", 32'(out_valid), 32'd1);
        check("div_off_md_start", 32'(md_start), 32'd0);
        check("div_off_stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
`endif

        // Reset during cycle 2 of a mult aborts it; no result is expected.
        in_valid = 1'b1; alu_op = 2'b10; funct = 6'd24;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_stall", 32'(stall), 32'd0);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_md_start", 32'(md_start), 32'd0);
        check("abort_md_kind", 32'(md_kind), 32'd0);
        check("abort_alu_ctrl", 32'(alu_ctrl), 32'd0);
        repeat (MD_LAT + 2) @(posedge clk);
        #1;

        // Reset beats a simultaneous accept.
        rst = 1'b1; in_valid = 1'b1; alu_op = 2'b00;
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("rst_priority_valid", 32'(out_valid), 32'd0);
        check("rst_priority_ctrl", 32'(alu_ctrl), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("final_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
